// File: rtl/comp_pkg.sv
// Shared types for the serial magnitude comparator:
// FSM state encoding, digit width and relation helpers.
package comp_pkg;

  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REL_EQ = 2'd0,
    REL_LT = 2'd1,
    REL_GT = 2'd2
  } rel_t;

  // Map a relation onto the one-hot {alb, aeb, agb} flags.
  function automatic logic [2:0] rel_flags(rel_t r);
    logic [2:0] f;
    f = 3'b010;
    unique case (r)
      REL_LT:  f = 3'b100;
      REL_GT:  f = 3'b001;
      default: f = 3'b010;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/comp_2bit.sv
// Combinational 2-bit unsigned magnitude comparator.
// Ports: a0/b0 digit MSBs, a1/b1 digit LSBs; alb/aeb/agb result flags.
module comp_2bit (
  input  logic a0,
  input  logic a1,
  input  logic b0,
  input  logic b1,
  output logic alb,
  output logic aeb,
  output logic agb
);

  logic msb_eq;
  logic lsb_eq;

  assign msb_eq = ~(a0 ^ b0);
  assign lsb_eq = ~(a1 ^ b1);

  assign aeb = msb_eq & lsb_eq;
  assign agb = (a0 & ~b0) | (msb_eq & a1 & ~b1);
  assign alb = (~a0 & b0) | (msb_eq & ~a1 & b1);

endmodule

// File: rtl/serial_mag_comp.sv
// Serial unsigned magnitude comparator, one 2-bit digit per cycle, MSB first.
// Ports: clk, rst (sync, active high), start, a, b -> busy, done, alb/aeb/agb.
// Optional: define CMP_EARLY_EXIT_EN to finish right after the first unequal digit.
module serial_mag_comp
  import comp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             alb,
  output logic             aeb,
  output logic             agb
);

  localparam int NDIG  = WIDTH / DIGIT_W;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  rel_t             rel_q, rel_d;
  logic [2:0]       flg_q, flg_d;

  logic dig_lt;
  logic dig_eq;
  logic dig_gt;
  rel_t rel_now;
  logic finish;

  comp_2bit u_dig (
    .a0  (a_sh_q[WIDTH-1]),
    .a1  (a_sh_q[WIDTH-2]),
    .b0  (b_sh_q[WIDTH-1]),
    .b1  (b_sh_q[WIDTH-2]),
    .alb (dig_lt),
    .aeb (dig_eq),
    .agb (dig_gt)
  );

  // The first unequal digit decides; later digits cannot override it.
  always_comb begin
    rel_now = rel_q;
    if (rel_q == REL_EQ) begin
      if (dig_lt)      rel_now = REL_LT;
      else if (dig_gt) rel_now = REL_GT;
      else             rel_now = REL_EQ;
    end
  end

  always_comb begin
    finish = (cnt_q == LAST);
`ifdef CMP_EARLY_EXIT_EN
    if (!dig_eq) finish = 1'b1;
`endif
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    flg_d   = flg_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          cnt_d   = '0;
          rel_d   = REL_EQ;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q << DIGIT_W;
        b_sh_d = b_sh_q << DIGIT_W;
        cnt_d  = cnt_q + 1'b1;
        rel_d  = rel_now;
        if (finish) begin
          state_d = DONE;
          flg_d   = rel_flags(rel_now);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      cnt_q   <= '0;
      rel_q   <= REL_EQ;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      flg_q   <= flg_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign alb  = flg_q[2];
  assign aeb  = flg_q[1];
  assign agb  = flg_q[0];

endmodule

// File: tb/tb_serial_mag_comp.sv
// Self-checking bench for serial_mag_comp (WIDTH=8).
// Honors CMP_EARLY_EXIT_EN when computing expected latency.
module tb_serial_mag_comp;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         alb;
  logic         aeb;
  logic         agb;

  int   checks;
  int   errors;
  logic pl, pe, pg;

  serial_mag_comp #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .alb   (alb),
    .aeb   (aeb),
    .agb   (agb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Done cycle counted from the accepting edge.
  function automatic int exp_done(input logic [W-1:0] x,
                                  input logic [W-1:0] y);
    int n;
    n = W / 2;
`ifdef CMP_EARLY_EXIT_EN
    for (int k = 0; k < n; k++) begin
      if (((x >> (W - 2 - 2 * k)) & 3) !=
          ((y >> (W - 2 - 2 * k)) & 3))
        return k + 2;
    end
`endif
    return n + 1;
  endfunction

  // Issues start with ta/tb now; returns in the done cycle, start low.
  task automatic run_op(input logic [W-1:0] ta,
                        input logic [W-1:0] tb,
                        input bit hold);
    int   dc;
    logic nl, ne, ng;
    dc = exp_done(ta, tb);
    nl = (ta < tb);
    ne = (ta == tb);
    ng = (ta > tb);
    start = 1'b1;
    a = ta;
    b = tb;
    tick();
    if (!hold) start = 1'b0;
    for (int c = 1; c <= dc; c++) begin
      chk("busy", 32'(busy), 32'(c < dc));
      chk("done", 32'(done), 32'(c == dc));
      if (c == dc) {pl, pe, pg} = {nl, ne, ng};
      chk("flags", 32'({alb, aeb, agb}), 32'({pl, pe, pg}));
      if (c < dc) begin
        if (hold) begin
          a = W'($urandom);
          b = W'($urandom);
        end
        tick();
      end
    end
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      chk("idle_busy", 32'(busy), 32'(0));
      chk("idle_done", 32'(done), 32'(0));
      chk("idle_flags", 32'({alb, aeb, agb}), 32'({pl, pe, pg}));
    end
  endtask

  initial begin
    logic [W-1:0] x, y;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    {pl, pe, pg} = 3'b000;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_flags", 32'({alb, aeb, agb}), 32'(0));

    // reset wins over start
    start = 1'b1;
    a = 8'h01;
    b = 8'h02;
    tick();
    chk("rst_prio_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    start = 1'b0;
    idle(1);

    run_op(8'hA5, 8'hA5, 0);
    idle(1);
    run_op(8'h80, 8'h7F, 0);
    idle(1);
    run_op(8'h12, 8'h13, 0);
    idle(1);
    run_op(8'h3C, 8'hC3, 1);
    idle(1);

    // back-to-back from the done cycle
    run_op(8'h55, 8'h54, 0);
    run_op(8'h00, 8'hFF, 0);
    idle(1);

    // reset in cycle 2 of RUN
    start = 1'b1;
    a = 8'hF0;
    b = 8'h0F;
    tick();
    start = 1'b0;
    chk("mid_busy1", 32'(busy), 32'(1));
    tick();
    chk("mid_busy2", 32'(busy), 32'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_done", 32'(done), 32'(0));
    chk("mid_rst_flags", 32'({alb, aeb, agb}), 32'(0));
    {pl, pe, pg} = 3'b000;
    idle(W / 2 + 2);
    run_op(8'h9A, 8'h9A, 0);
    idle(1);

    for (int i = 0; i < 24; i++) begin
      x = W'($urandom);
      case (i % 4)
        0:       y = x;
        1:       y = x ^ W'(1 << $urandom_range(0, W - 1));
        default: y = W'($urandom);
      endcase
      run_op(x, y, (i % 5) == 2);
      if ((i % 3) != 0) idle(1);
    end
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
